// File: rtl/rst_seq_pkg.sv
// Shared state encodings and defaults for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_GATE    = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_GATE_CYCLES = 2;

endpackage

// File: rtl/rst_seq_timer.sv
// Interval down-counter shared by the HOLD, RELEASE and GATE intervals.
module rst_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  // Parked at zero outside timed states, so it can never wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: staged domain release, clock-gate control and software reset handshake.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  output logic                   SW_RST_ACK,
  output logic [NUM_DOMAINS-1:0] DOM_RST,
  output logic [NUM_DOMAINS-1:0] CLK_EN,
  output logic                   SEQ_DONE,
  output logic                   BUSY
);

  localparam int unsigned     IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

  if (NUM_DOMAINS == 0 || CNT_W == 0 || CNT_W > 32 ||
      HOLD_CYCLES == 0 || GAP_CYCLES == 0 || GATE_CYCLES == 0 ||
      64'(HOLD_CYCLES) >= CNT_LIM || 64'(GAP_CYCLES) >= CNT_LIM ||
      64'(GATE_CYCLES) >= CNT_LIM) begin : g_param_check
    $error("rst_seq_ctrl: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYCLES - 1);

  seq_state_e             state_q, state_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [NUM_DOMAINS-1:0] dom_rst_n, clk_en_n;
  logic                   seq_done_n, ack_n;
  logic                   req_d, req_rise;
  logic                   pending_q, pending_n;
  logic                   sw_flag_q, sw_flag_n;
  logic                   rel_bit;
  logic                   tmr_load, tmr_run, tmr_exp;
  logic [CNT_W-1:0]       tmr_val;

  rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .run      (tmr_run),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  assign req_rise = SW_RST_REQ & ~req_d;

  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    dom_rst_n  = DOM_RST;
    clk_en_n   = CLK_EN;
    seq_done_n = SEQ_DONE;
    ack_n      = 1'b0;
    sw_flag_n  = sw_flag_q;
    rel_bit    = 1'b0;
    tmr_load   = 1'b0;
    tmr_run    = 1'b0;
    tmr_val    = '0;
    // A new edge in the same cycle DONE consumes pending re-arms it.
    pending_n  = req_rise ? 1'b1 : ((state_q == ST_DONE) ? 1'b0 : pending_q);

    case (state_q)
      ST_ASSERT: begin
        state_n   = ST_HOLD;
        dom_rst_n = '1;
        clk_en_n  = '1;
        tmr_load  = 1'b1;
        tmr_val   = HOLD_LD;
      end
      ST_HOLD: begin
        tmr_run = 1'b1;
        if (tmr_exp) begin
          state_n  = ST_RELEASE;
          idx_n    = '0;
          rel_bit  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_RELEASE: begin
        tmr_run = 1'b1;
        if (tmr_exp) begin
          if (32'(idx_q) < NUM_DOMAINS - 1) begin
            idx_n    = idx_q + 1'b1;
            rel_bit  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else begin
            state_n    = ST_DONE;
            seq_done_n = 1'b1;
            ack_n      = sw_flag_q;
            sw_flag_n  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (pending_q) begin
          state_n    = ST_GATE;
          seq_done_n = 1'b0;
          clk_en_n   = '0;
          tmr_load   = 1'b1;
          tmr_val    = GATE_LD;
        end
      end
      ST_GATE: begin
        tmr_run = 1'b1;
        if (tmr_exp) begin
          state_n   = ST_ASSERT;
          dom_rst_n = '1;
          clk_en_n  = '0;
          sw_flag_n = 1'b1;
        end
      end
      default: begin
        state_n    = ST_ASSERT;
        dom_rst_n  = '1;
        clk_en_n   = '0;
        seq_done_n = 1'b0;
      end
    endcase

    if (rel_bit) begin
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
        if (i == 32'(idx_n)) dom_rst_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_ASSERT;
      idx_q      <= '0;
      DOM_RST    <= '1;
      CLK_EN     <= '0;
      SEQ_DONE   <= 1'b0;
      SW_RST_ACK <= 1'b0;
      req_d      <= 1'b0;
      pending_q  <= 1'b0;
      sw_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      DOM_RST    <= dom_rst_n;
      CLK_EN     <= clk_en_n;
      SEQ_DONE   <= seq_done_n;
      SW_RST_ACK <= ack_n;
      req_d      <= SW_RST_REQ;
      pending_q  <= pending_n;
      sw_flag_q  <= sw_flag_n;
    end
  end

  assign BUSY = (state_q != ST_DONE);

endmodule
